// File: rtl/object_pingpong_buffer_pkg.sv
// Shared object package: the object record stored by the frame buffers and a
// width helper for cursors/counts that must represent 0..SIZE inclusive.
// No ports; imported by the buffer, its banks and its interface.
package object_pingpong_buffer_pkg;

   // One detected object as produced by the detection stage.
   typedef struct packed {
      logic [11:0] x;
      logic [11:0] y;
      logic [11:0] w;
      logic [11:0] h;
      logic [7:0]  cls;
   } object_t;

   localparam int OBJ_DEFAULT_SIZE = 50;

   // Width able to hold every value 0..size inclusive (a full bank included).
   function automatic int obj_cnt_w(input int size);
      return $clog2(size + 1);
   endfunction

endpackage

// File: rtl/object_pingpong_buffer_if.sv
// Write/read handshake bundle of the ping-pong object buffer.
// Ports: wr_data/wr_valid/wr_ready/wr_count/wr_overflow (producer side),
//        rd_ready/rd_data/rd_valid/rd_last/rd_count/rd_overflow (consumer side).
// master = producer+consumer environment, slave = the buffer itself.
interface object_pingpong_buffer_if
   import object_pingpong_buffer_pkg::*;
#(
   parameter int SIZE = OBJ_DEFAULT_SIZE
);
   localparam int CNT_W = obj_cnt_w(SIZE);

   object_t            wr_data;
   logic               wr_valid;
   logic               wr_ready;
   logic [CNT_W-1:0]   wr_count;
   logic               wr_overflow;

   logic               rd_ready;
   object_t            rd_data;
   logic               rd_valid;
   logic               rd_last;
   logic [CNT_W-1:0]   rd_count;
   logic               rd_overflow;

   modport slave (
      input  wr_data, wr_valid, rd_ready,
      output wr_ready, wr_count, wr_overflow,
             rd_data, rd_valid, rd_last, rd_count, rd_overflow
   );

   modport master (
      output wr_data, wr_valid, rd_ready,
      input  wr_ready, wr_count, wr_overflow,
             rd_data, rd_valid, rd_last, rd_count, rd_overflow
   );

endinterface

// File: rtl/object_pingpong_buffer_bank.sv
// object_bank: SIZE-entry object memory, one synchronous write port and one
// asynchronous read port. Write lands at the clock edge; read is zero latency.
// Ports: i_clock, i_wr_en/i_wr_addr/i_wr_data, i_rd_addr -> o_rd_data. No backpressure.
module object_bank
   import object_pingpong_buffer_pkg::*;
#(
   parameter int SIZE = OBJ_DEFAULT_SIZE,
   parameter int AW   = obj_cnt_w(SIZE)
) (
   input  logic          i_clock,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  object_t       i_wr_data,
   input  logic [AW-1:0] i_rd_addr,
   output object_t       o_rd_data
);

   // Addresses are count-wide (can reach SIZE); the array only needs IW bits.
   localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

   object_t         r_mem [SIZE];
   logic [IW-1:0]   w_wr_idx;
   logic [IW-1:0]   w_rd_idx;
   logic            w_wr_in_range;
   logic            w_rd_in_range;

   assign w_wr_idx      = i_wr_addr[IW-1:0];
   assign w_rd_idx      = i_rd_addr[IW-1:0];
   assign w_wr_in_range = (int'(i_wr_addr) < SIZE);
   assign w_rd_in_range = (int'(i_rd_addr) < SIZE);

   // Contents are deliberately not reset; occupancy is tracked by the cursors.
   always_ff @(posedge i_clock) begin
      if (i_wr_en && w_wr_in_range) begin
         r_mem[w_wr_idx] <= i_wr_data;
      end
   end

   // A fully consumed bank parks the read cursor at SIZE; return zero there.
   assign o_rd_data = w_rd_in_range ? r_mem[w_rd_idx] : '0;

endmodule

// File: rtl/object_pingpong_buffer.sv
// Ping-pong object buffer: producer fills one bank while the consumer drains the
// other; i_next_frame swaps banks. rd_data is combinational (zero latency).
// Backpressure: wr_ready drops when the write bank is full (extra writes dropped,
// flagged in wr_overflow); reads advance only on rd_valid && rd_ready.
// Ports: i_clock, i_reset_n (sync, active low), i_next_frame, bus (slave modport).
module object_pingpong_buffer
   import object_pingpong_buffer_pkg::*;
#(
   parameter int SIZE = OBJ_DEFAULT_SIZE
) (
   input  logic                    i_clock,
   input  logic                    i_reset_n,
   input  logic                    i_next_frame,
   object_pingpong_buffer_if.slave bus
);

   localparam int               CNT_W  = obj_cnt_w(SIZE);
   localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(SIZE);
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

   logic             r_wr_bank;
   logic [CNT_W-1:0] r_wr_cursor;
   logic [CNT_W-1:0] r_rd_cursor;
   logic [CNT_W-1:0] r_rd_count;
   logic             r_wr_overflow;
   logic             r_rd_overflow;

   logic             w_wr_ready;
   logic             w_wr_accept;
   logic             w_wr_drop;
   logic             w_rd_valid;
   logic             w_rd_transfer;
   logic [CNT_W-1:0] w_frame_count;
   logic             w_bank0_we;
   logic             w_bank1_we;
   object_t          w_bank0_rd;
   object_t          w_bank1_rd;

   // ---------------- write side ----------------
   assign w_wr_ready  = (r_wr_cursor != SIZE_C);
   assign w_wr_accept = bus.wr_valid && w_wr_ready;
   assign w_wr_drop   = bus.wr_valid && !w_wr_ready;

   // A write coincident with the swap still belongs to the outgoing frame.
   assign w_frame_count = r_wr_cursor + (w_wr_accept ? ONE_C : '0);

   // ---------------- read side ----------------
   // Forcing rd_valid low on the swap cycle guarantees no transfer races the
   // cursor reset.
   assign w_rd_valid    = (r_rd_cursor < r_rd_count) && !i_next_frame;
   assign w_rd_transfer = w_rd_valid && bus.rd_ready;

   // ---------------- state ----------------
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_wr_bank     <= 1'b0;
         r_wr_cursor   <= '0;
         r_rd_cursor   <= '0;
         r_rd_count    <= '0;
         r_wr_overflow <= 1'b0;
         r_rd_overflow <= 1'b0;
      end else if (i_next_frame) begin
         r_wr_bank     <= ~r_wr_bank;
         r_rd_count    <= w_frame_count;
         r_rd_overflow <= r_wr_overflow || w_wr_drop;
         r_wr_cursor   <= '0;
         r_wr_overflow <= 1'b0;
         r_rd_cursor   <= '0;
      end else begin
         if (w_wr_accept) begin
            r_wr_cursor <= r_wr_cursor + ONE_C;
         end
         if (w_wr_drop) begin
            r_wr_overflow <= 1'b1;
         end
         if (w_rd_transfer) begin
            r_rd_cursor <= r_rd_cursor + ONE_C;
         end
      end
   end

   // ---------------- banks ----------------
   assign w_bank0_we = w_wr_accept && (r_wr_bank == 1'b0);
   assign w_bank1_we = w_wr_accept && (r_wr_bank == 1'b1);

   object_bank #(
      .SIZE (SIZE),
      .AW   (CNT_W)
   ) u_bank0 (
      .i_clock   (i_clock),
      .i_wr_en   (w_bank0_we),
      .i_wr_addr (r_wr_cursor),
      .i_wr_data (bus.wr_data),
      .i_rd_addr (r_rd_cursor),
      .o_rd_data (w_bank0_rd)
   );

   object_bank #(
      .SIZE (SIZE),
      .AW   (CNT_W)
   ) u_bank1 (
      .i_clock   (i_clock),
      .i_wr_en   (w_bank1_we),
      .i_wr_addr (r_wr_cursor),
      .i_wr_data (bus.wr_data),
      .i_rd_addr (r_rd_cursor),
      .o_rd_data (w_bank1_rd)
   );

   // ---------------- outputs ----------------
   assign bus.wr_ready    = w_wr_ready;
   assign bus.wr_count    = r_wr_cursor;
   assign bus.wr_overflow = r_wr_overflow;

   // The read bank is always the one not being written.
   assign bus.rd_data     = r_wr_bank ? w_bank0_rd : w_bank1_rd;
   assign bus.rd_valid    = w_rd_valid;
   assign bus.rd_last     = w_rd_valid && (r_rd_cursor == (r_rd_count - ONE_C));
   assign bus.rd_count    = r_rd_count;
   assign bus.rd_overflow = r_rd_overflow;

endmodule

// File: tb/tb_object_pingpong_buffer.sv
module tb_object_pingpong_buffer;
   import object_pingpong_buffer_pkg::*;

   localparam int SIZE = 4;

   logic clock = 1'b0;
   logic reset_n;
   logic next_frame;

   int total = 0;
   int bad   = 0;

   object_pingpong_buffer_if #(.SIZE(SIZE)) bus ();

   object_pingpong_buffer #(.SIZE(SIZE)) dut (
      .i_clock      (clock),
      .i_reset_n    (reset_n),
      .i_next_frame (next_frame),
      .bus          (bus)
   );

   always #5 clock = ~clock;

   // Reference model: frames as queues of objects.
   object_t m_wq[$];
   object_t m_rq[$];
   int      m_rpos = 0;
   bit      m_wovf = 0;
   bit      m_rovf = 0;

   function automatic object_t rnd_obj();
      logic [63:0] t;
      t = {$urandom, $urandom};
      return object_t'(t[$bits(object_t)-1:0]);
   endfunction

   // Apply inputs mid-low-phase; outputs are settled 1 time unit later.
   task automatic drive(input logic rst, input logic nf, input logic wv,
                        input logic rr, input object_t wd);
      @(negedge clock);
      reset_n       = rst;
      next_frame    = nf;
      bus.wr_valid  = wv;
      bus.rd_ready  = rr;
      bus.wr_data   = wd;
      #1;
   endtask

   // Advance the model with the applied inputs, then take the clock edge.
   task automatic tick();
      bit acc, drop;
      if (!reset_n) begin
         m_wq.delete(); m_rq.delete();
         m_rpos = 0; m_wovf = 0; m_rovf = 0;
      end else begin
         acc  = bus.wr_valid && (m_wq.size() < SIZE);
         drop = bus.wr_valid && !acc;
         if (acc) m_wq.push_back(bus.wr_data);
         if (next_frame) begin
            m_rq   = m_wq;
            m_rpos = 0;
            m_rovf = m_wovf || drop;
            m_wq.delete();
            m_wovf = 0;
         end else begin
            if (drop) m_wovf = 1;
            if (bus.rd_ready && (m_rpos < m_rq.size())) m_rpos++;
         end
      end
      @(posedge clock);
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 0, '0); tick();
      drive(0, 0, 0, 0, '0); tick();
      drive(1, 0, 0, 0, '0);
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
      total++; if (int'(bus.rd_count) !== 0) begin bad++; $display("FAIL reset_rd_count: got %0d want 0", bus.rd_count); end
      total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready: got %b want 1", bus.wr_ready); end
      total++; if (int'(bus.wr_count) !== 0) begin bad++; $display("FAIL reset_wr_count: got %0d want 0", bus.wr_count); end
      total++; if ({bus.wr_overflow, bus.rd_overflow} !== 2'b00) begin bad++; $display("FAIL reset_overflow: got %b want 00", {bus.wr_overflow, bus.rd_overflow}); end
      total++; if (bus.rd_last !== 1'b0) begin bad++; $display("FAIL reset_rd_last: got %b want 0", bus.rd_last); end
      tick();
   endtask

   task automatic test_basic_frame();
      object_t objs[3];
      object_t d;
      for (int i = 0; i < 3; i++) objs[i] = rnd_obj();
      d = rnd_obj();
      for (int i = 0; i < 3; i++) begin drive(1, 0, 1, 0, objs[i]); tick(); end
      drive(1, 1, 0, 1, '0);
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL basic_nf_rd_valid: got %b want 0", bus.rd_valid); end
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, (i == 0), 1, d);
         total++; if (int'(bus.rd_count) !== 3) begin bad++; $display("FAIL basic_rd_count: got %0d want 3", bus.rd_count); end
         total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL basic_rd_valid[%0d]: got %b want 1", i, bus.rd_valid); end
         total++; if (bus.rd_data !== objs[i]) begin bad++; $display("FAIL basic_rd_data[%0d]: got %h want %h", i, bus.rd_data, objs[i]); end
         total++; if (bus.rd_last !== 1'(i == 2)) begin bad++; $display("FAIL basic_rd_last[%0d]: got %b want %b", i, bus.rd_last, (i == 2)); end
         tick();
      end
      drive(1, 0, 0, 1, '0);
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL basic_drained: got %b want 0", bus.rd_valid); end
      total++; if (int'(bus.wr_count) !== 1) begin bad++; $display("FAIL basic_wr_count: got %0d want 1", bus.wr_count); end
      tick();
   endtask

   task automatic test_overflow();
      drive(1, 1, 0, 0, '0); tick();   // start from an empty write bank
      for (int k = 0; k < 5; k++) begin
         drive(1, 0, 1, 0, rnd_obj());
         total++; if (bus.wr_ready !== 1'(k < 4)) begin bad++; $display("FAIL ovf_wr_ready[%0d]: got %b want %b", k, bus.wr_ready, (k < 4)); end
         tick();
      end
      drive(1, 0, 0, 0, '0);
      total++; if (bus.wr_overflow !== 1'b1) begin bad++; $display("FAIL ovf_wr_overflow: got %b want 1", bus.wr_overflow); end
      total++; if (int'(bus.wr_count) !== 4) begin bad++; $display("FAIL ovf_wr_count: got %0d want 4", bus.wr_count); end
      tick();
      drive(1, 1, 0, 0, '0); tick();
      drive(1, 0, 0, 0, '0);
      total++; if (int'(bus.rd_count) !== 4) begin bad++; $display("FAIL ovf_rd_count: got %0d want 4", bus.rd_count); end
      total++; if (bus.rd_overflow !== 1'b1) begin bad++; $display("FAIL ovf_rd_overflow: got %b want 1", bus.rd_overflow); end
      total++; if (bus.wr_overflow !== 1'b0) begin bad++; $display("FAIL ovf_wr_overflow_clr: got %b want 0", bus.wr_overflow); end
      total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL ovf_wr_ready_after: got %b want 1", bus.wr_ready); end
      tick();
   endtask

   task automatic test_coincident();
      object_t o[3];
      for (int i = 0; i < 3; i++) o[i] = rnd_obj();
      drive(1, 0, 1, 0, o[0]); tick();
      drive(1, 0, 1, 0, o[1]); tick();
      drive(1, 1, 1, 0, o[2]); tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 1, '0);
         total++; if (int'(bus.rd_count) !== 3) begin bad++; $display("FAIL coin_rd_count: got %0d want 3", bus.rd_count); end
         total++; if (bus.rd_overflow !== 1'b0) begin bad++; $display("FAIL coin_rd_overflow: got %b want 0", bus.rd_overflow); end
         total++; if (bus.rd_data !== o[i]) begin bad++; $display("FAIL coin_rd_data[%0d]: got %h want %h", i, bus.rd_data, o[i]); end
         tick();
      end
   endtask

   task automatic test_partial_swap();
      object_t p[3];
      object_t q[2];
      for (int i = 0; i < 3; i++) p[i] = rnd_obj();
      for (int i = 0; i < 2; i++) q[i] = rnd_obj();
      for (int i = 0; i < 3; i++) begin drive(1, 0, 1, 0, p[i]); tick(); end
      drive(1, 1, 0, 0, '0); tick();
      drive(1, 0, 1, 1, q[0]);
      total++; if (bus.rd_data !== p[0]) begin bad++; $display("FAIL part_first: got %h want %h", bus.rd_data, p[0]); end
      tick();
      drive(1, 0, 1, 0, q[1]);
      total++; if (bus.rd_data !== p[1]) begin bad++; $display("FAIL part_second: got %h want %h", bus.rd_data, p[1]); end
      tick();
      drive(1, 1, 0, 1, '0);
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL part_nf_rd_valid: got %b want 0", bus.rd_valid); end
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 0, 1, '0);
         total++; if (int'(bus.rd_count) !== 2) begin bad++; $display("FAIL part_rd_count: got %0d want 2", bus.rd_count); end
         total++; if (bus.rd_data !== q[i]) begin bad++; $display("FAIL part_new_data[%0d]: got %h want %h", i, bus.rd_data, q[i]); end
         total++; if (bus.rd_last !== 1'(i == 1)) begin bad++; $display("FAIL part_rd_last[%0d]: got %b want %b", i, bus.rd_last, (i == 1)); end
         tick();
      end
      drive(1, 0, 0, 1, '0);
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL part_drained: got %b want 0", bus.rd_valid); end
      tick();
   endtask

   task automatic test_reset_mid();
      object_t t0;
      t0 = rnd_obj();
      for (int i = 0; i < 3; i++) begin drive(1, 0, 1, 0, rnd_obj()); tick(); end
      drive(1, 1, 0, 0, '0); tick();
      drive(1, 0, 1, 1, rnd_obj()); tick();
      drive(1, 0, 1, 0, rnd_obj()); tick();
      drive(0, 0, 1, 1, rnd_obj()); tick();
      drive(1, 0, 0, 1, '0);
      total++; if (int'(bus.rd_count) !== 0 || int'(bus.wr_count) !== 0) begin bad++; $display("FAIL rmid_counts: got rd=%0d wr=%0d want 0 0", bus.rd_count, bus.wr_count); end
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL rmid_rd_valid: got %b want 0", bus.rd_valid); end
      total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL rmid_wr_ready: got %b want 1", bus.wr_ready); end
      tick();
      drive(1, 0, 1, 0, t0); tick();
      drive(1, 1, 0, 0, '0); tick();
      drive(1, 0, 0, 0, '0);
      total++; if (int'(bus.rd_count) !== 1) begin bad++; $display("FAIL rmid_after_count: got %0d want 1", bus.rd_count); end
      total++; if (bus.rd_data !== t0 || bus.rd_last !== 1'b1) begin bad++; $display("FAIL rmid_after_data: got %h last=%b want %h last=1", bus.rd_data, bus.rd_last, t0); end
      tick();
   endtask

   task automatic test_random();
      bit exp_v;
      for (int n = 0; n < 600; n++) begin
         drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6), rnd_obj());
         exp_v = (m_rpos < m_rq.size()) && !next_frame;
         total++; if (bus.wr_ready !== 1'(m_wq.size() < SIZE)) begin bad++; $display("FAIL rnd_wr_ready@%0d: got %b want %b", n, bus.wr_ready, (m_wq.size() < SIZE)); end
         total++; if (int'(bus.wr_count) !== m_wq.size()) begin bad++; $display("FAIL rnd_wr_count@%0d: got %0d want %0d", n, bus.wr_count, m_wq.size()); end
         total++; if (bus.wr_overflow !== m_wovf) begin bad++; $display("FAIL rnd_wr_overflow@%0d: got %b want %b", n, bus.wr_overflow, m_wovf); end
         total++; if (bus.rd_valid !== exp_v) begin bad++; $display("FAIL rnd_rd_valid@%0d: got %b want %b", n, bus.rd_valid, exp_v); end
         total++; if (bus.rd_last !== 1'(exp_v && (m_rpos == m_rq.size() - 1))) begin bad++; $display("FAIL rnd_rd_last@%0d: got %b", n, bus.rd_last); end
         total++; if (int'(bus.rd_count) !== m_rq.size()) begin bad++; $display("FAIL rnd_rd_count@%0d: got %0d want %0d", n, bus.rd_count, m_rq.size()); end
         total++; if (bus.rd_overflow !== m_rovf) begin bad++; $display("FAIL rnd_rd_overflow@%0d: got %b want %b", n, bus.rd_overflow, m_rovf); end
         if (exp_v) begin
            total++; if (bus.rd_data !== m_rq[m_rpos]) begin bad++; $display("FAIL rnd_rd_data@%0d: got %h want %h", n, bus.rd_data, m_rq[m_rpos]); end
         end
         tick();
      end
   endtask

   initial begin
      reset_n      = 1'b0;
      next_frame   = 1'b0;
      bus.wr_valid = 1'b0;
      bus.rd_ready = 1'b0;
      bus.wr_data  = '0;
      test_reset();
      test_basic_frame();
      test_overflow();
      test_coincident();
      test_partial_swap();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/object_pingpong_buffer.md
Name: object_pingpong_buffer

Overview:
- Double-buffered (ping-pong) successor to the single-bank object buffer.
- The detection stage writes the current frame's objects into one bank while the consumer reads the previous frame's objects from the other bank.
- Banks swap on the `next_frame` pulse.
- Adds a ready/valid read handshake, a last-object marker, per-frame object counts, overflow reporting, and cursors wide enough to represent a full bank.

Parameters:
- SIZE, 50, object slots per bank (minimum 1).
- CNT_W, $clog2(SIZE+1), derived width of cursors and counts. Represents 0..SIZE inclusive. Not to be overridden.

Ports:
- clock, input, 1, single clock; all logic on rising edge.
- reset_n, input, 1, synchronous active-low reset.
- next_frame, input, 1, single-cycle pulse marking frame boundary; triggers bank swap.
- wr_data, input, object_t, object to store.
- wr_valid, input, 1, write request.
- wr_ready, output, 1, write bank has a free slot.
- wr_count, output, CNT_W, objects accepted into the write bank this frame.
- wr_overflow, output, 1, sticky: a write was dropped this frame.
- rd_ready, input, 1, consumer accepts rd_data.
- rd_data, output, object_t, object at the read cursor of the read bank.
- rd_valid, output, 1, rd_data holds an unread object.
- rd_last, output, 1, rd_data is the final object of the read frame.
- rd_count, output, CNT_W, objects in the read bank (previous frame).
- rd_overflow, output, 1, previous frame overflowed (frame-level flag).

Behaviour:
- State registers:
  - wr_bank (1 bit); the read bank is always ~wr_bank.
  - wr_cursor, rd_cursor, rd_count (CNT_W each).
  - wr_overflow, rd_overflow.
  - Two banks of SIZE object_t entries.
- Reset (reset_n low at a rising edge) takes priority over everything:
  - wr_bank=0, all cursors and counts 0, both overflow flags 0.
  - Memory contents are not cleared.
  - Resulting outputs: wr_ready=1, rd_valid=0, rd_last=0, rd_count=0, wr_count=0.
  - Applies mid-frame and mid-read; no partial state survives.
- Write:
  - wr_ready = (wr_cursor != SIZE); wr_count = wr_cursor.
  - Accept = wr_valid && wr_ready. On accept: store at bank[wr_bank][wr_cursor]; wr_cursor+1 at the next edge.
  - wr_valid while full: data dropped, wr_cursor unchanged, wr_overflow<=1.
- Read:
  - rd_data = bank[~wr_bank][rd_cursor], combinational, zero latency.
  - rd_valid = (rd_cursor < rd_count) && !next_frame.
  - rd_last = rd_valid && (rd_cursor == rd_count-1).
  - Transfer = rd_valid && rd_ready; rd_cursor+1 at the next edge.
  - rd_ready with rd_valid low: no effect. rd_data is don't-care when rd_valid is low.
- next_frame (reset_n high):
  - wr_bank<=~wr_bank.
  - rd_count<=wr_cursor+(write accepted this cycle ? 1 : 0). A write coincident with next_frame lands in the outgoing bank and is counted.
  - rd_overflow<=wr_overflow, including a drop occurring this same cycle.
  - wr_cursor<=0, wr_overflow<=0, rd_cursor<=0.
  - Unread objects of the old read bank are discarded.
  - No read transfer occurs on the next_frame cycle, because rd_valid is forced low.
- Back-to-back next_frame pulses are legal. A frame with zero writes yields rd_count=0, so rd_valid stays low.
- Arithmetic:
  - Cursors never exceed SIZE; no wrap-around.
  - All comparisons are unsigned at CNT_W.
  - SIZE must be assigned with explicit CNT_W-bit sizing.

Decomposition:
- object_t stays in the shared object package.
- Add a localparam helper for CNT_W to the same package if other buffers reuse it.
- Natural sub-module: object_bank, a SIZE-entry memory with one synchronous write port and one asynchronous read port, instantiated twice.
  - Write enable is gated by wr_bank; the read mux is selected by ~wr_bank.

Test Plan (SIZE=4 unless stated):
- Reset: hold reset_n low 2 cycles, then release → rd_valid=0, rd_count=0, wr_ready=1, wr_count=0, both overflow flags 0.
- Basic frame:
  - Stimulus: write A,B,C, pulse next_frame, hold rd_ready=1.
  - Response: rd_count=3. A,B,C appear on 3 consecutive cycles, rd_last only with C, then rd_valid=0.
  - Concurrently write D: wr_count=1 and D is not visible on the read side.
- Overflow:
  - Stimulus: 5 consecutive writes.
  - Response: wr_ready drops after the 4th, the 5th is dropped, wr_overflow=1.
  - After next_frame: rd_count=4, rd_overflow=1, wr_overflow=0, wr_ready=1.
- Coincident write: write X,Y, then Z in the same cycle as next_frame → rd_count=3, read order X,Y,Z.
- Partial read then swap:
  - Stimulus: frame of 3, read 1 object, pulse next_frame while rd_ready=1, with a new frame of 2 objects.
  - Response: rd_valid=0 during the pulse, then the new frame reads from cursor 0 with 2 objects; the old 2 objects are never presented.
- Reset mid-operation: while reading object 2 of 3 with the write bank holding 2, drive reset_n low 1 cycle → next cycle all counts 0, rd_valid=0, wr_bank=0.
